// File: rtl/counter_0_99.sv
// Two-digit synchronous BCD up-counter (00..99) with preset load, terminal count
// and cascade carry. WRAP selects wrap-to-00 or saturate-at-99 after 99.
module counter_0_99 #(
  parameter bit WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       init,
  input  logic       load,
  input  logic [7:0] preset,
  input  logic       en,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       tc,
  output logic       cout
);

  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] DigitMax = DigitW'(9);

  logic [DigitW-1:0] units_q, units_d;
  logic [DigitW-1:0] tens_q, tens_d;
  logic [DigitW-1:0] preset_units_c, preset_tens_c;
  logic              units_max_c, tens_max_c;

  // Next-state: load beats increment; non-BCD preset digits load as 0.
  always_comb begin
    units_d        = units_q;
    tens_d         = tens_q;
    preset_units_c = preset[DigitW-1:0];
    preset_tens_c  = preset[2*DigitW-1:DigitW];
    if (preset_units_c > DigitMax) preset_units_c = '0;
    if (preset_tens_c > DigitMax)  preset_tens_c  = '0;
    units_max_c    = (units_q == DigitMax);
    tens_max_c     = (tens_q == DigitMax);

    if (load) begin
      units_d = preset_units_c;
      tens_d  = preset_tens_c;
    end else if (en) begin
      if (!units_max_c) begin
        units_d = units_q + DigitW'(1);
      end else if (!tens_max_c) begin
        units_d = '0;
        tens_d  = tens_q + DigitW'(1);
      end else if (WRAP) begin
        units_d = '0;
        tens_d  = '0;
      end
    end
  end

  // Digit registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!init) begin
      units_q <= '0;
      tens_q  <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign units = units_q;
  assign tens  = tens_q;
  assign tc    = units_max_c & tens_max_c;
  assign cout  = en & tc;

endmodule
